match_ctrl: RTL and testbench

//  Best-of-N match sequencer for the tug-of-war game. Sits between the user_in

---
 rtl/match_ctrl.sv | 143 ++++++++++++++
 tb/tb_match_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/match_ctrl.sv
// match_ctrl: best-of-N match sequencer for the tug-of-war game.
// It forwards presses only during play and counts round wins. It holds each
// round result for a fixed time, pulses a round reset before every new round
// and freezes the display once a player reaches WIN_ROUNDS.
module match_ctrl #(
  parameter int WIN_ROUNDS  = 7,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       L_press,
  input  logic       R_press,
  input  logic       L_win,
  input  logic       R_win,
  output logic       L_out,
  output logic       R_out,
  output logic       round_rst,
  output logic [3:0] L_score,
  output logic [3:0] R_score,
  output logic [1:0] round_winner,
  output logic       match_over,
  output logic [6:0] hex_L,
  output logic [6:0] hex_R
);

  localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    WIN_CNT   = 4'(WIN_ROUNDS);

  typedef enum logic [2:0] {
    READY = 3'd0,
    CLEAR = 3'd1,
    PLAY  = 3'd2,
    HOLD  = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      l_score_q, l_score_d;
  logic [3:0]      r_score_q, r_score_d;
  logic [1:0]      winner_q, winner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Active-low seven-segment pattern for one hex digit (segment g is bit 6).
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // State, score, result and hold-timer registers; rst returns to READY from anywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= READY;
      l_score_q <= 4'd0;
      r_score_q <= 4'd0;
      winner_q  <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      l_score_q <= l_score_d;
      r_score_q <= r_score_d;
      winner_q  <= winner_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic: round start, win accounting, hold timing and match end.
  always_comb begin
    state_d   = state_q;
    l_score_d = l_score_q;
    r_score_d = r_score_q;
    winner_d  = winner_q;
    cnt_d     = cnt_q;
    case (state_q)
      READY: begin
        if (L_press || R_press) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = PLAY;
      end
      PLAY: begin
        if (L_win && R_win) begin
          // Simultaneous wins count as a draw: nobody scores.
          winner_d = 2'b00;
          cnt_d    = HOLD_LOAD;
          state_d  = HOLD;
        end else if (L_win) begin
          l_score_d = l_score_q + 4'd1;
          winner_d  = 2'b10;
          cnt_d     = HOLD_LOAD;
          state_d   = (l_score_d == WIN_CNT) ? OVER : HOLD;
        end else if (R_win) begin
          r_score_d = r_score_q + 4'd1;
          winner_d  = 2'b01;
          cnt_d     = HOLD_LOAD;
          state_d   = (r_score_d == WIN_CNT) ? OVER : HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = CLEAR;
        else             cnt_d   = cnt_q - 1'b1;
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

  // Outputs are decoded directly from the registers; presses pass with zero latency.
  always_comb begin
    L_out        = L_press & (state_q == PLAY);
    R_out        = R_press & (state_q == PLAY);
    round_rst    = rst | (state_q == CLEAR);
    L_score      = l_score_q;
    R_score      = r_score_q;
    round_winner = winner_q;
    match_over   = (state_q == OVER);
    hex_L        = seg7(l_score_q);
    hex_R        = seg7(r_score_q);
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl: stimulus pushes expected outputs from a
// behavioural game model, an independent monitor pops and compares each cycle.
module tb_match_ctrl;

  localparam int WIN  = 3;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst, L_press, R_press, L_win, R_win;
  logic       L_out, R_out, round_rst, match_over;
  logic [3:0] L_score, R_score;
  logic [1:0] round_winner;
  logic [6:0] hex_L, hex_R;

  match_ctrl #(.WIN_ROUNDS(WIN), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .L_press(L_press), .R_press(R_press),
    .L_win(L_win), .R_win(R_win), .L_out(L_out), .R_out(R_out),
    .round_rst(round_rst), .L_score(L_score), .R_score(R_score),
    .round_winner(round_winner), .match_over(match_over),
    .hex_L(hex_L), .hex_R(hex_R)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       lo, ro, rr, mo;
    logic [3:0] ls, rs;
    logic [1:0] rw;
    logic [6:0] hl, hr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  logic [6:0] seg_tab [16];

  // Game model: what the players would see, tracked as plain flags and counts.
  bit waiting;      // idle, waiting for a starting press
  bit clearing;     // this cycle is the round-reset cycle
  bit playing;      // presses are live
  int hold_left;    // remaining result-display cycles (0 = not displaying)
  bit finished;     // match decided
  int lwins, rwins;
  logic [1:0] last;

  task automatic model_reset();
    waiting = 1; clearing = 0; playing = 0; hold_left = 0; finished = 0;
    lwins = 0; rwins = 0; last = 2'b00;
  endtask

  task automatic step(input bit r, input bit lp, input bit rp, input bit lw, input bit rw);
    exp_t e;
    @(negedge clk);
    cyc++;
    rst = r; L_press = lp; R_press = rp; L_win = lw; R_win = rw;
    e.cyc = cyc;
    e.lo  = lp && playing;
    e.ro  = rp && playing;
    e.rr  = r || clearing;
    e.mo  = finished;
    e.ls  = 4'(lwins);
    e.rs  = 4'(rwins);
    e.rw  = last;
    e.hl  = seg_tab[lwins];
    e.hr  = seg_tab[rwins];
    exp_q.push_back(e);
    // advance the model to the next cycle
    if (r) begin
      model_reset();
    end else if (waiting) begin
      if (lp || rp) begin waiting = 0; clearing = 1; end
    end else if (clearing) begin
      clearing = 0; playing = 1;
    end else if (playing) begin
      if (lw || rw) begin
        playing = 0;
        if (lw && rw) last = 2'b00;
        else if (lw) begin lwins++; last = 2'b10; end
        else begin rwins++; last = 2'b01; end
        if (lwins == WIN || rwins == WIN) finished = 1;
        else hold_left = HOLD;
      end
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) clearing = 1;
    end
  endtask

  task automatic chk(input string name, input int c, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, want);
    end
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("L_out",        e.cyc, int'(L_out),        int'(e.lo));
        chk("R_out",        e.cyc, int'(R_out),        int'(e.ro));
        chk("round_rst",    e.cyc, int'(round_rst),    int'(e.rr));
        chk("match_over",   e.cyc, int'(match_over),   int'(e.mo));
        chk("L_score",      e.cyc, int'(L_score),      int'(e.ls));
        chk("R_score",      e.cyc, int'(R_score),      int'(e.rs));
        chk("round_winner", e.cyc, int'(round_winner), int'(e.rw));
        chk("hex_L",        e.cyc, int'(hex_L),        int'(e.hl));
        chk("hex_R",        e.cyc, int'(hex_R),        int'(e.hr));
        $display("cycle %0d: Lo=%0b Ro=%0b rr=%0b Ls=%0d Rs=%0d rw=%02b over=%0b",
                 e.cyc, L_out, R_out, round_rst, L_score, R_score, round_winner, match_over);
      end
    end
  end

  task automatic win_round(input bit lw, input bit rw);
    step(0, 0, 0, lw, rw);
    repeat (5) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    rst = 1; L_press = 0; R_press = 0; L_win = 0; R_win = 0;
    model_reset();
    @(posedge clk);

    // reset cycle, then idle in READY
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);          // win pulse in READY ignored... but press starts
    step(0, 0, 0, 0, 0);          // round reset cycle
    step(0, 1, 0, 0, 0);          // press forwarded in PLAY
    step(0, 1, 1, 0, 0);
    win_round(0, 1);              // right wins round 1
    step(0, 1, 1, 0, 0);
    win_round(1, 1);              // draw
    win_round(1, 0);              // left 1
    step(0, 0, 0, 1, 0);          // left 2
    step(0, 1, 0, 0, 0);          // press mid-hold dropped
    step(1, 0, 0, 0, 0);          // reset mid-hold
    repeat (6) step(0, 0, 0, 0, 0);  // counter must not resume
    step(0, 1, 0, 0, 0);          // start new match
    step(0, 0, 0, 0, 0);
    win_round(1, 0);
    win_round(1, 0);
    win_round(1, 0);              // third left win: match over
    repeat (8) step(0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1);

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    @(negedge clk);
    #5;
    chk("scoreboard_drained", cyc, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
